// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the CV32E40P WFI sequencer.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    WFI_RUN   = 2'd0,
    WFI_DRAIN = 2'd1,
    WFI_SLEEP = 2'd2,
    WFI_WAKE  = 2'd3
  } wfi_state_e;

  localparam int unsigned WFI_WAKE_CNT_W = 4;

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module cv32e40p_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {WIDTH{1'b0}};
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cv32e40p_wfi_sequencer.sv
// WFI sequencer: drains the core, hands over to the sleep unit, and holds fetch
// for a fixed wake-up interval before retiring the WFI.
module cv32e40p_wfi_sequencer
  import cv32e40p_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic        clk_ungated_i,
  input  logic        rst_n,
  input  logic        wfi_req_i,
  input  logic        debug_wfi_no_sleep_i,
  input  logic        if_busy_i,
  input  logic        lsu_busy_i,
  input  logic        apu_busy_i,
  input  logic        irq_wu_i,
  input  logic        debug_req_i,
  input  logic        sleep_cnt_clr_i,
  output logic        halt_if_o,
  output logic        wfi_done_o,
  output logic        ctrl_busy_o,
  output logic        sleep_o,
  output logic        wake_from_sleep_o,
  output logic [31:0] sleep_cycles_o
);

  localparam logic [WFI_WAKE_CNT_W-1:0] WAKE_CNT_INIT = WFI_WAKE_CNT_W'(WAKE_CYCLES - 1);

  wfi_state_e                state_q;
  wfi_state_e                state_d;
  logic [WFI_WAKE_CNT_W-1:0] wake_cnt_q;
  logic [WFI_WAKE_CNT_W-1:0] wake_cnt_d;
  logic                      wake_s;
  logic                      idle_s;
  logic                      in_sleep_s;

  assign wake_s     = irq_wu_i | debug_req_i;
  assign idle_s     = ~if_busy_i & ~lsu_busy_i & ~apu_busy_i;
  assign in_sleep_s = (state_q == WFI_SLEEP);

  // Next-state, wake counter and retire pulse
  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    wfi_done_o = 1'b0;
    case (state_q)
      WFI_RUN: begin
        if (wfi_req_i && (debug_wfi_no_sleep_i || wake_s)) begin
          wfi_done_o = 1'b1;
        end else if (wfi_req_i) begin
          state_d = WFI_DRAIN;
        end else begin
          state_d = WFI_RUN;
        end
      end
      WFI_DRAIN: begin
        // A wake during drain aborts the WFI even if the core is already idle
        if (wake_s) begin
          wfi_done_o = 1'b1;
          state_d    = WFI_RUN;
        end else if (idle_s) begin
          state_d = WFI_SLEEP;
        end else begin
          state_d = WFI_DRAIN;
        end
      end
      WFI_SLEEP: begin
        if (wake_s) begin
          state_d    = WFI_WAKE;
          wake_cnt_d = WAKE_CNT_INIT;
        end else begin
          state_d = WFI_SLEEP;
        end
      end
      WFI_WAKE: begin
        if (wake_cnt_q == {WFI_WAKE_CNT_W{1'b0}}) begin
          wfi_done_o = 1'b1;
          state_d    = WFI_RUN;
        end else begin
          wake_cnt_d = wake_cnt_q - WFI_WAKE_CNT_W'(1);
        end
      end
      default: begin
        state_d    = WFI_RUN;
        wake_cnt_d = {WFI_WAKE_CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state and wake counter registers
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WFI_RUN;
      wake_cnt_q <= {WFI_WAKE_CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  assign halt_if_o         = (state_q != WFI_RUN);
  assign ctrl_busy_o       = ~in_sleep_s;
  assign sleep_o           = in_sleep_s;
  // Combinational so the gated clock restarts in the same cycle the wake arrives
  assign wake_from_sleep_o = in_sleep_s & wake_s;

  cv32e40p_sat_counter #(
    .WIDTH (32)
  ) u_sleep_cnt (
    .clk   (clk_ungated_i),
    .rst_n (rst_n),
    .inc   (in_sleep_s),
    .clr   (sleep_cnt_clr_i),
    .cnt   (sleep_cycles_o)
  );

endmodule

// File: tb/tb_cv32e40p_wfi_sequencer.sv
// Directed and random bench for cv32e40p_wfi_sequencer, checked against a cycle model.
module tb_cv32e40p_wfi_sequencer;

  localparam int WAKE_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wfi_req, dbg_nosleep, if_busy, lsu_busy, apu_busy, irq_wu, debug_req, cnt_clr;
  logic        halt_if, wfi_done, ctrl_busy, sleep, wake_fs;
  logic [31:0] sleep_cycles;
  logic        sc_inc, sc_clr;
  logic [3:0]  sc_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: mode 0=run 1=drain 2=sleep 3=wake; wake_left = WAKE cycles still to go
  int     m_mode;
  int     m_wake_left;
  longint m_cnt;
  logic   m_done;

  always #5 clk = ~clk;

  cv32e40p_wfi_sequencer #(.WAKE_CYCLES(WAKE_CYC)) dut (
    .clk_ungated_i        (clk),
    .rst_n                (rst_n),
    .wfi_req_i            (wfi_req),
    .debug_wfi_no_sleep_i (dbg_nosleep),
    .if_busy_i            (if_busy),
    .lsu_busy_i           (lsu_busy),
    .apu_busy_i           (apu_busy),
    .irq_wu_i             (irq_wu),
    .debug_req_i          (debug_req),
    .sleep_cnt_clr_i      (cnt_clr),
    .halt_if_o            (halt_if),
    .wfi_done_o           (wfi_done),
    .ctrl_busy_o          (ctrl_busy),
    .sleep_o              (sleep),
    .wake_from_sleep_o    (wake_fs),
    .sleep_cycles_o       (sleep_cycles)
  );

  cv32e40p_sat_counter #(.WIDTH(4)) u_sc (
    .clk (clk), .rst_n (rst_n), .inc (sc_inc), .clr (sc_clr), .cnt (sc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_wake_left = 0; m_cnt = 0; m_done = 1'b0;
  endtask

  // One clock cycle: drive, compare all outputs against the model, advance the model
  task automatic step(input logic req, input logic dbg, input logic ifb, input logic lsub,
                      input logic apub, input logic irq, input logic dreq, input logic clr);
    logic wake, idle;
    @(posedge clk);
    #1;
    wfi_req = req; dbg_nosleep = dbg; if_busy = ifb; lsu_busy = lsub; apu_busy = apub;
    irq_wu = irq; debug_req = dreq; cnt_clr = clr;
    wake = irq | dreq;
    idle = !ifb && !lsub && !apub;
    m_done = (m_mode == 0 && req && (dbg || wake)) || (m_mode == 1 && wake) ||
             (m_mode == 3 && m_wake_left == 1);
    @(negedge clk);
    chk("halt_if",   {31'd0, halt_if},   {31'd0, m_mode != 0});
    chk("ctrl_busy", {31'd0, ctrl_busy}, {31'd0, m_mode != 2});
    chk("sleep",     {31'd0, sleep},     {31'd0, m_mode == 2});
    chk("wake_fs",   {31'd0, wake_fs},   {31'd0, m_mode == 2 && wake});
    chk("wfi_done",  {31'd0, wfi_done},  {31'd0, m_done});
    chk("sleep_cnt", sleep_cycles, m_cnt[31:0]);
    if (clr) m_cnt = 0;
    else if (m_mode == 2 && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    case (m_mode)
      0: if (req && !(dbg || wake)) m_mode = 1;
      1: if (wake) m_mode = 0; else if (idle) m_mode = 2;
      2: if (wake) begin m_mode = 3; m_wake_left = WAKE_CYC; end
      3: if (m_wake_left == 1) m_mode = 0; else m_wake_left--;
      default: m_mode = 0;
    endcase
  endtask

  initial begin
    logic pend;
    rst_n = 1'b0;
    wfi_req = 0; dbg_nosleep = 0; if_busy = 0; lsu_busy = 0; apu_busy = 0;
    irq_wu = 0; debug_req = 0; cnt_clr = 0; sc_inc = 0; sc_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_halt", {31'd0, halt_if}, 32'd0);
    chk("rst_busy", {31'd0, ctrl_busy}, 32'd1);
    chk("rst_sleep", {31'd0, sleep}, 32'd0);
    chk("rst_cnt", sleep_cycles, 32'd0);
    #2 rst_n = 1'b1;

    // Debug NOP: retire in the same cycle, no halt
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("nop_done", {31'd0, wfi_done}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Full sleep: busy LSU through cycle 2, interrupt at cycle 10
    for (int c = 0; c <= 12; c++) begin
      step(1'b1, 1'b0, 1'b0, c < 3, 1'b0, c == 10, 1'b0, 1'b0);
      if (c == 4)  chk("sleep_c4", {31'd0, sleep}, 32'd1);
      if (c == 10) chk("wfs_c10", {31'd0, wake_fs}, 32'd1);
      if (c == 11) chk("cnt_c11", sleep_cycles, 32'd7);
      if (c == 12) chk("done_c12", {31'd0, wfi_done}, 32'd1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Drain abort via debug request while IF stays busy
    for (int c = 0; c <= 4; c++) begin
      step(c <= 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c == 3, 1'b0);
      if (c == 3) chk("abort_done", {31'd0, wfi_done}, 32'd1);
      if (c == 4) chk("abort_run", {31'd0, halt_if}, 32'd0);
    end
    chk("abort_cnt", sleep_cycles, 32'd7);

    // Clear while sleeping, then asynchronous reset mid-sleep
    for (int c = 0; c <= 6; c++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c == 5);
      if (c == 6) chk("clr_cnt", sleep_cycles, 32'd0);
    end
    #2;
    wfi_req = 0; irq_wu = 0; debug_req = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, ctrl_busy}, 32'd1);
    chk("arst_sleep", {31'd0, sleep}, 32'd0);
    chk("arst_halt", {31'd0, halt_if}, 32'd0);
    chk("arst_cnt", sleep_cycles, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Saturation on a narrow instance of the same counter, then clear beats increment
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk); #1 sc_inc = 1'b1;
      @(negedge clk);
      chk("sat_cnt", {28'd0, sc_cnt}, (i - 1 > 15) ? 32'd15 : 32'(i - 1));
    end
    @(posedge clk); #1 sc_clr = 1'b1;
    @(posedge clk); #1 sc_clr = 1'b0; sc_inc = 1'b0;
    @(negedge clk);
    chk("sat_clr", {28'd0, sc_cnt}, 32'd0);

    // Random traffic; WFI request held until it retires
    pend = 1'b0;
    for (int n = 0; n < 500; n++) begin
      pend = pend | ($urandom % 6 == 0);
      step(pend, $urandom % 12 == 0, $urandom % 3 == 0, $urandom % 3 == 0, $urandom % 4 == 0,
           $urandom % 10 == 0, $urandom % 25 == 0, $urandom % 60 == 0);
      if (m_done) pend = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_wfi_sequencer.md
# cv32e40p_wfi_sequencer

WFI sequencing controller for CV32E40P that sits between the ID-stage decoder and `cv32e40p_sleep_unit`. It accepts a WFI request, halts fetch, and drains outstanding IF/LSU/APU activity. It then drops `ctrl_busy` so the sleep unit gates the core clock, detects wake events, and holds fetch for a programmable wake-up interval before retiring the WFI. It runs on the free-running clock and also keeps a saturating sleep-cycle counter for performance monitoring.

## Interface
Parameters:
- `WAKE_CYCLES`, default 2: cycles spent in WAKE before WFI retires; legal range 1..15.

Ports:
- `clk_ungated_i`  in  1  free-running (ungated) clock
- `rst_n`  in  1  asynchronous active-low reset
- `wfi_req_i`  in  1  WFI decoded in ID; level, held until `wfi_done_o`
- `debug_wfi_no_sleep_i`  in  1  debug mode, single-step or trigger active; WFI acts as NOP
- `if_busy_i`, `lsu_busy_i`, `apu_busy_i`  in  1 each  sub-unit busy flags
- `irq_wu_i`  in  1  enabled interrupt pending (wake source, independent of mstatus.MIE)
- `debug_req_i`  in  1  external debug request (wake source)
- `sleep_cnt_clr_i`  in  1  synchronous clear of `sleep_cycles_o`
- `halt_if_o`  out  1  stall fetch / hold ID
- `wfi_done_o`  out  1  one-cycle pulse, WFI retires
- `ctrl_busy_o`  out  1  drives sleep unit `ctrl_busy_i`
- `sleep_o`  out  1  core is in SLEEP state
- `wake_from_sleep_o`  out  1  drives sleep unit `wake_from_sleep_i`
- `sleep_cycles_o`  out  32  cycles spent in SLEEP, saturating

## Operation
- Wake condition: `wake = irq_wu_i | debug_req_i`.
- Drained condition: `idle = !if_busy_i & !lsu_busy_i & !apu_busy_i`.
- FSM states, all registered:
  - RUN: `ctrl_busy_o=1`, `halt_if_o=0`.
    - `wfi_req_i & (debug_wfi_no_sleep_i | wake)`: pulse `wfi_done_o`, stay in RUN.
    - `wfi_req_i` otherwise: go to DRAIN.
  - DRAIN: `halt_if_o=1`, `ctrl_busy_o=1`. Priority order:
    - `wake`: pulse `wfi_done_o`, go to RUN (abort).
    - `idle`: go to SLEEP.
    - otherwise: stay.
  - SLEEP: `halt_if_o=1`, `ctrl_busy_o=0`, `sleep_o=1`, `wake_from_sleep_o=wake` (combinational).
    - On `wake`: go to WAKE and load the wake counter with `WAKE_CYCLES-1`.
  - WAKE: `halt_if_o=1`, `ctrl_busy_o=1`.
    - Wake counter decrements each cycle.
    - When counter==0: pulse `wfi_done_o`, go to RUN.
    - Wake inputs are ignored in this state.
- `wake_from_sleep_o` is 0 in every state other than SLEEP.
- `wfi_req_i` is ignored in DRAIN, SLEEP and WAKE.
- Sleep counter:
  - Increments by 1 on every cycle spent in SLEEP.
  - Saturates at 0xFFFF_FFFF.
  - `sleep_cnt_clr_i` clears it; clear wins over a simultaneous increment.
- Wake counter is 4 bits wide; its value is don't-care outside WAKE.

## Timing
- Reset values: state RUN, `halt_if_o=0`, `wfi_done_o=0`, `ctrl_busy_o=1`, `sleep_o=0`, `wake_from_sleep_o=0`, `sleep_cycles_o=0`, wake counter 0.
- Reset is asynchronous in any state; the FSM returns to RUN and the sleep counter clears.
- NOP WFI (early wake or debug): `wfi_done_o` is asserted in the same cycle as `wfi_req_i`.
- Minimum sleep path:
  - `wfi_req_i` at cycle 0.
  - DRAIN at cycle 1.
  - SLEEP at cycle 2 if `idle` already holds in cycle 1.
- `ctrl_busy_o` falls in the first SLEEP cycle. The sleep unit sees `core_busy_q=0` one cycle later, and the clock gates from then on.
- Wake sequence:
  - `wake` seen in SLEEP cycle N: `wake_from_sleep_o=1` in cycle N, which re-enables the gated clock combinationally.
  - WAKE occupies cycles N+1 .. N+`WAKE_CYCLES`.
  - `wfi_done_o` is asserted in cycle N+`WAKE_CYCLES`; RUN starts the following cycle.
- If `wake` and `idle` are both true in DRAIN, the abort to RUN takes priority.
- Counter increments are registered; `sleep_cycles_o` lags state by one cycle.

## Structure
- `cv32e40p_pkg` gains typedef enum `wfi_state_e` {WFI_RUN, WFI_DRAIN, WFI_SLEEP, WFI_WAKE}.
- `cv32e40p_pkg` also gains constant `WFI_WAKE_CNT_W = 4`.
- One sub-module, `cv32e40p_sat_counter` (parameter WIDTH, inputs `inc`, `clr`, output `cnt`), instantiated with WIDTH=32 for the sleep counter.
- FSM and wake counter are implemented inline in `cv32e40p_wfi_sequencer`.

## Test plan
- Debug NOP:
  - Stimulus: `wfi_req_i=1`, `debug_wfi_no_sleep_i=1`.
  - Required: `wfi_done_o=1` in the same cycle; `halt_if_o` stays 0; `sleep_cycles_o` stays 0.
- Full sleep with WAKE_CYCLES=2:
  - Stimulus: `wfi_req_i` at cycle 0, `lsu_busy_i=1` until cycle 3, `irq_wu_i` at cycle 10.
  - Required: SLEEP in cycles 4..10; `ctrl_busy_o=0` in cycles 4..10; `wake_from_sleep_o=1` at cycle 10; `wfi_done_o` at cycle 12; `sleep_cycles_o=7` at cycle 11.
- Drain abort:
  - Stimulus: `if_busy_i=1` throughout, `debug_req_i` pulse at cycle 3.
  - Required: `wfi_done_o` at cycle 3, RUN at cycle 4, SLEEP never entered.
- Saturation and clear:
  - Stimulus: force the counter to 0xFFFF_FFFE, then stay in SLEEP for 3 cycles.
  - Required: counter holds at 0xFFFF_FFFF.
  - Stimulus: assert `sleep_cnt_clr_i` while still in SLEEP.
  - Required: counter reads 0 on the next cycle.
- Reset mid-sleep:
  - Stimulus: assert `rst_n=0` in SLEEP, asynchronously with respect to the clock.
  - Required: outputs take their reset values immediately, including `ctrl_busy_o=1` and `sleep_o=0`.
